// File: rtl/dual_port_ram_arbiter_if.sv
// Requester-side bus of dual_port_ram_arbiter: request handshake plus read responses.
// master = requester side, slave = arbiter side.
interface dual_port_ram_arbiter_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 6,
    parameter int NUM_REQ    = 4
);
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0]            req_we;
    logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata;
    logic [NUM_REQ-1:0]            req_ready;
    logic [NUM_REQ-1:0]            rsp_valid;
    logic [NUM_REQ*DATA_WIDTH-1:0] rsp_rdata;

    modport master (
        output req_valid, req_we, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata
    );
endinterface

// File: rtl/dual_port_ram_arbiter.sv
// Round-robin arbiter sharing both ports of dual_port_ram among NUM_REQ requesters.
// Up to two grants per cycle (P -> port A, S -> port B), same-address hazard
// blocking on S, and routing of registered read data back to the issuer.
// Optional macro ARB_HAZARD_STATS_EN adds hazard_count / grant_count outputs.
module dual_port_ram_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 6,
    parameter int NUM_REQ    = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    dual_port_ram_arbiter_if.slave bus,
    output logic [ADDR_WIDTH-1:0] ram_addr_a,
    output logic [ADDR_WIDTH-1:0] ram_addr_b,
    output logic [DATA_WIDTH-1:0] ram_data_a,
    output logic [DATA_WIDTH-1:0] ram_data_b,
    output logic                  ram_we_a,
    output logic                  ram_we_b,
    input  logic [DATA_WIDTH-1:0] ram_q_a,
    input  logic [DATA_WIDTH-1:0] ram_q_b
`ifdef ARB_HAZARD_STATS_EN
    ,
    output logic [15:0]           hazard_count,
    output logic [15:0]           grant_count
`endif
);
    localparam int ID_W = $clog2(NUM_REQ);

    function automatic logic [ID_W-1:0] wrap_inc(input logic [ID_W-1:0] v);
        return (int'(v) == NUM_REQ - 1) ? '0 : v + 1'b1;
    endfunction

    logic [ID_W-1:0]       r_ptr;
    logic [ID_W-1:0]       w_scan;
    logic                  w_p_found, w_s_found;
    logic [ID_W-1:0]       w_p_id, w_s_id;
    logic [ADDR_WIDTH-1:0] w_addr_p, w_addr_s;
    logic [DATA_WIDTH-1:0] w_wd_p, w_wd_s;
    logic                  w_we_p, w_we_s;
    logic                  w_hazard, w_p_gnt, w_s_gnt;
    logic [NUM_REQ-1:0]    w_ready;
    logic [NUM_REQ-1:0]    w_rsp_valid;
    logic [NUM_REQ*DATA_WIDTH-1:0] w_rsp_rdata;
    logic [NUM_REQ*DATA_WIDTH-1:0] r_hold;
    logic                  r_tag_a_vld, r_tag_b_vld;
    logic [ID_W-1:0]       r_tag_a_id, r_tag_b_id;

    // Scan from the priority pointer, wrapping, to find the first two valid requesters.
    always_comb begin
        w_p_found = 1'b0;
        w_s_found = 1'b0;
        w_p_id    = '0;
        w_s_id    = '0;
        w_scan    = r_ptr;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (bus.req_valid[w_scan]) begin
                if (!w_p_found) begin
                    w_p_found = 1'b1;
                    w_p_id    = w_scan;
                end else if (!w_s_found) begin
                    w_s_found = 1'b1;
                    w_s_id    = w_scan;
                end
            end
            w_scan = wrap_inc(w_scan);
        end
    end

    assign w_addr_p = bus.req_addr[w_p_id*ADDR_WIDTH +: ADDR_WIDTH];
    assign w_addr_s = bus.req_addr[w_s_id*ADDR_WIDTH +: ADDR_WIDTH];
    assign w_wd_p   = bus.req_wdata[w_p_id*DATA_WIDTH +: DATA_WIDTH];
    assign w_wd_s   = bus.req_wdata[w_s_id*DATA_WIDTH +: DATA_WIDTH];
    assign w_we_p   = bus.req_we[w_p_id];
    assign w_we_s   = bus.req_we[w_s_id];

    // Two reads of one address are harmless; any write involvement blocks S.
    assign w_hazard = w_p_found && w_s_found && (w_addr_p == w_addr_s) && (w_we_p || w_we_s);
    assign w_p_gnt  = w_p_found && !rst;
    assign w_s_gnt  = w_s_found && !w_hazard && !rst;

    // Grant vector: at most one port per requester, never during reset.
    always_comb begin
        w_ready = '0;
        if (w_p_gnt) w_ready[w_p_id] = 1'b1;
        if (w_s_gnt) w_ready[w_s_id] = 1'b1;
    end
    assign bus.req_ready = w_ready;

    assign ram_addr_a = w_p_gnt ? w_addr_p : '0;
    assign ram_data_a = w_p_gnt ? w_wd_p   : '0;
    assign ram_we_a   = w_p_gnt && w_we_p;
    assign ram_addr_b = w_s_gnt ? w_addr_s : '0;
    assign ram_data_b = w_s_gnt ? w_wd_s   : '0;
    assign ram_we_b   = w_s_gnt && w_we_s;

    // Advance the priority pointer past the last requester served.
    always_ff @(posedge clk) begin
        if (rst)          r_ptr <= '0;
        else if (w_s_gnt) r_ptr <= wrap_inc(w_s_id);
        else if (w_p_gnt) r_ptr <= wrap_inc(w_p_id);
    end

    // Read tags registered alongside the RAM's own q register; tags seen in reset are dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tag_a_vld <= 1'b0;
            r_tag_b_vld <= 1'b0;
            r_tag_a_id  <= '0;
            r_tag_b_id  <= '0;
        end else begin
            r_tag_a_vld <= w_p_gnt && !w_we_p;
            r_tag_b_vld <= w_s_gnt && !w_we_s;
            r_tag_a_id  <= w_p_id;
            r_tag_b_id  <= w_s_id;
        end
    end

    // Route the live RAM outputs to the tagged requester; other slices show held data.
    always_comb begin
        w_rsp_valid = '0;
        w_rsp_rdata = r_hold;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (r_tag_a_vld && r_tag_a_id == ID_W'(i)) begin
                w_rsp_valid[i] = 1'b1;
                w_rsp_rdata[i*DATA_WIDTH +: DATA_WIDTH] = ram_q_a;
            end else if (r_tag_b_vld && r_tag_b_id == ID_W'(i)) begin
                w_rsp_valid[i] = 1'b1;
                w_rsp_rdata[i*DATA_WIDTH +: DATA_WIDTH] = ram_q_b;
            end
        end
    end
    assign bus.rsp_valid = w_rsp_valid;
    assign bus.rsp_rdata = w_rsp_rdata;

    // Keep the last delivered word per requester so slices stay stable between pulses.
    always_ff @(posedge clk) begin
        if (rst) r_hold <= '0;
        else     r_hold <= w_rsp_rdata;
    end

`ifdef ARB_HAZARD_STATS_EN
    logic [15:0] r_hazard_cnt;
    logic [15:0] r_grant_cnt;

    // Hazard counter saturates; grant counter wraps.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hazard_cnt <= '0;
            r_grant_cnt  <= '0;
        end else begin
            if (w_hazard && r_hazard_cnt != 16'hFFFF) r_hazard_cnt <= r_hazard_cnt + 16'd1;
            r_grant_cnt <= r_grant_cnt + 16'(w_p_gnt) + 16'(w_s_gnt);
        end
    end
    assign hazard_count = r_hazard_cnt;
    assign grant_count  = r_grant_cnt;
`endif
endmodule

// File: tb/tb_dual_port_ram_arbiter.sv
// Testbench for dual_port_ram_arbiter: directed scenarios then randomized traffic,
// all checked against a queue-based reference model of the arbitration rules.
module tb_dual_port_ram_arbiter;
    localparam int N  = 4;
    localparam int AW = 6;
    localparam int DW = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dual_port_ram_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REQ(N)) bus ();

    logic [AW-1:0] ram_addr_a, ram_addr_b;
    logic [DW-1:0] ram_data_a, ram_data_b, ram_q_a, ram_q_b;
    logic          ram_we_a, ram_we_b;
`ifdef ARB_HAZARD_STATS_EN
    logic [15:0]   hazard_count, grant_count;
`endif

    dual_port_ram_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REQ(N)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .ram_addr_a (ram_addr_a),
        .ram_addr_b (ram_addr_b),
        .ram_data_a (ram_data_a),
        .ram_data_b (ram_data_b),
        .ram_we_a   (ram_we_a),
        .ram_we_b   (ram_we_b),
        .ram_q_a    (ram_q_a),
        .ram_q_b    (ram_q_b)
`ifdef ARB_HAZARD_STATS_EN
        ,
        .hazard_count (hazard_count),
        .grant_count  (grant_count)
`endif
    );

    // Behavioural dual-port RAM with registered outputs.
    logic [DW-1:0] ram_mem [0:63];
    always @(posedge clk) begin
        if (ram_we_a) ram_mem[ram_addr_a] <= ram_data_a;
        if (ram_we_b) ram_mem[ram_addr_b] <= ram_data_b;
        ram_q_a <= ram_mem[ram_addr_a];
        ram_q_b <= ram_mem[ram_addr_b];
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference model state
    int            m_ptr;
    logic [DW-1:0] m_mem [0:63];
    logic [N-1:0]  m_vld;
    logic [DW-1:0] m_data [N];
    int            m_haz, m_gnt;
    // Per-cycle expectations
    bit            e_pg, e_sg, e_haz;
    int            e_p, e_s;
    logic [N-1:0]  e_ready;

    function automatic logic [AW-1:0] addr_of(input int j);
        return bus.req_addr[j*AW +: AW];
    endfunction
    function automatic logic [DW-1:0] wd_of(input int j);
        return bus.req_wdata[j*DW +: DW];
    endfunction

    task automatic model_eval();
        int order[$];
        order = {};
        for (int k = 0; k < N; k++) begin
            int j;
            j = (m_ptr + k) % N;
            if (bus.req_valid[j]) order.push_back(j);
        end
        e_pg = 0; e_sg = 0; e_haz = 0; e_p = 0; e_s = 0;
        if (order.size() > 0) e_p = order[0];
        if (order.size() > 1) begin
            e_s   = order[1];
            e_haz = (addr_of(e_p) == addr_of(e_s)) && (bus.req_we[e_p] || bus.req_we[e_s]);
        end
        if (!rst) begin
            e_pg = order.size() > 0;
            e_sg = order.size() > 1 && !e_haz;
        end
        e_ready = '0;
        if (e_pg) e_ready[e_p] = 1'b1;
        if (e_sg) e_ready[e_s] = 1'b1;
    endtask

    task automatic model_update();
        if (rst) begin
            m_ptr = 0; m_vld = '0; m_haz = 0; m_gnt = 0;
            for (int i = 0; i < N; i++) m_data[i] = '0;
        end else begin
            m_vld = '0;
            if (e_pg && !bus.req_we[e_p]) begin m_vld[e_p] = 1'b1; m_data[e_p] = m_mem[addr_of(e_p)]; end
            if (e_sg && !bus.req_we[e_s]) begin m_vld[e_s] = 1'b1; m_data[e_s] = m_mem[addr_of(e_s)]; end
            if (e_pg && bus.req_we[e_p]) m_mem[addr_of(e_p)] = wd_of(e_p);
            if (e_sg && bus.req_we[e_s]) m_mem[addr_of(e_s)] = wd_of(e_s);
            if (e_haz && m_haz < 16'hFFFF) m_haz++;
            m_gnt = (m_gnt + int'(e_pg) + int'(e_sg)) % 65536;
            if (e_sg)      m_ptr = (e_s + 1) % N;
            else if (e_pg) m_ptr = (e_p + 1) % N;
        end
    endtask

    // Sample at the falling edge and compare everything the model predicts.
    task automatic sample();
        logic [N*DW-1:0] exp_rd;
        @(negedge clk);
        model_eval();
        for (int i = 0; i < N; i++) exp_rd[i*DW +: DW] = m_data[i];
        check_val("req_ready", 64'(bus.req_ready), 64'(e_ready));
        check_val("ram_addr_a", 64'(ram_addr_a), e_pg ? 64'(addr_of(e_p)) : 64'd0);
        check_val("ram_data_a", 64'(ram_data_a), e_pg ? 64'(wd_of(e_p)) : 64'd0);
        check_val("ram_we_a", 64'(ram_we_a), 64'(e_pg && bus.req_we[e_p]));
        check_val("ram_addr_b", 64'(ram_addr_b), e_sg ? 64'(addr_of(e_s)) : 64'd0);
        check_val("ram_data_b", 64'(ram_data_b), e_sg ? 64'(wd_of(e_s)) : 64'd0);
        check_val("ram_we_b", 64'(ram_we_b), 64'(e_sg && bus.req_we[e_s]));
        check_val("rsp_valid", 64'(bus.rsp_valid), 64'(m_vld));
        check_val("rsp_rdata", 64'(bus.rsp_rdata), 64'(exp_rd));
`ifdef ARB_HAZARD_STATS_EN
        check_val("hazard_count", 64'(hazard_count), 64'(m_haz));
        check_val("grant_count", 64'(grant_count), 64'(m_gnt));
`endif
    endtask

    task automatic advance();
        model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input bit v, input bit we, input int addr, input int data);
        bus.req_valid[i]          = v;
        bus.req_we[i]             = we;
        bus.req_addr[i*AW +: AW]  = AW'(addr);
        bus.req_wdata[i*DW +: DW] = DW'(data);
    endtask

    task automatic clear_reqs();
        bus.req_valid = '0; bus.req_we = '0; bus.req_addr = '0; bus.req_wdata = '0;
    endtask

    initial begin
        for (int a = 0; a < 64; a++) begin ram_mem[a] = '0; m_mem[a] = '0; end
        m_ptr = 0; m_vld = '0; m_haz = 0; m_gnt = 0;
        for (int i = 0; i < N; i++) m_data[i] = '0;
        clear_reqs();
        rst = 1'b1;
        @(posedge clk); #1;

        // Reset, then idle
        for (int c = 0; c < 2; c++) begin
            sample();
            check_val("rst_ready", 64'(bus.req_ready), 64'd0);
            check_val("rst_we", 64'({ram_we_a, ram_we_b}), 64'd0);
            advance();
        end
        rst = 1'b0;
        for (int c = 0; c < 2; c++) begin sample(); advance(); end

        // Two writes, then two reads
        set_req(0, 1, 1, 8'h01, 8'h33);
        set_req(1, 1, 1, 8'h02, 8'h44);
        sample();
        check_val("wr_ready", 64'(bus.req_ready), 64'h3);
        check_val("wr_port_a", 64'({ram_addr_a, ram_data_a}), 64'({6'h01, 8'h33}));
        check_val("wr_port_b", 64'({ram_addr_b, ram_data_b}), 64'({6'h02, 8'h44}));
        advance();
        clear_reqs();
        set_req(2, 1, 0, 8'h01, 0);
        set_req(3, 1, 0, 8'h02, 0);
        sample();
        check_val("rd_ready", 64'(bus.req_ready), 64'hC);
        advance();
        clear_reqs();
        sample();
        check_val("rd_rsp_valid", 64'(bus.rsp_valid), 64'hC);
        check_val("rd_data2", 64'(bus.rsp_rdata[2*DW +: DW]), 64'h33);
        check_val("rd_data3", 64'(bus.rsp_rdata[3*DW +: DW]), 64'h44);
        advance();

        // Write-write hazard
        set_req(0, 1, 1, 8'h03, 8'h55);
        set_req(1, 1, 1, 8'h03, 8'h66);
        sample();
        check_val("haz_ready0", 64'(bus.req_ready), 64'h1);
        advance();
        set_req(0, 0, 0, 0, 0);
        sample();
        check_val("haz_ready1", 64'(bus.req_ready), 64'h2);
        advance();
        clear_reqs();
        set_req(2, 1, 0, 8'h03, 0);
        sample(); advance();
        clear_reqs();
        sample();
        check_val("haz_readback", 64'(bus.rsp_rdata[2*DW +: DW]), 64'h66);
        advance();

        // Read-read same address
        set_req(0, 1, 0, 8'h01, 0);
        set_req(1, 1, 0, 8'h01, 0);
        sample();
        check_val("rr_ready", 64'(bus.req_ready), 64'h3);
        advance();
        clear_reqs();
        sample();
        check_val("rr_rsp_valid", 64'(bus.rsp_valid), 64'h3);
        check_val("rr_data0", 64'(bus.rsp_rdata[0 +: DW]), 64'h33);
        check_val("rr_data1", 64'(bus.rsp_rdata[DW +: DW]), 64'h33);
        advance();

        // Round-robin fairness from ptr = 0
        rst = 1'b1; sample(); advance(); rst = 1'b0;
        for (int i = 0; i < N; i++) set_req(i, 1, 0, 8 + i, 0);
        for (int c = 0; c < 5; c++) begin
            sample();
            check_val("rr_pair", 64'(bus.req_ready), (c % 2 == 1) ? 64'hC : 64'h3);
            advance();
        end
        clear_reqs();
        sample(); advance();

        // Reset in the middle of a read
        set_req(0, 1, 0, 8'h02, 0);
        sample(); advance();
        clear_reqs();
        rst = 1'b1;
        set_req(1, 1, 0, 8'h05, 0);
        sample();
        check_val("mid_rst_ready", 64'(bus.req_ready), 64'd0);
        check_val("mid_rst_rsp", 64'(bus.rsp_valid[0]), 64'd1);
        check_val("mid_rst_data", 64'(bus.rsp_rdata[0 +: DW]), 64'h44);
        advance();
        rst = 1'b0;
        clear_reqs();
        sample();
        check_val("post_rst_rsp", 64'(bus.rsp_valid), 64'd0);
`ifdef ARB_HAZARD_STATS_EN
        check_val("post_rst_haz", 64'(hazard_count), 64'd0);
        check_val("post_rst_gnt", 64'(grant_count), 64'd0);
`endif
        advance();

        // Randomized traffic on a narrow address range to provoke hazards
        for (int c = 0; c < 400; c++) begin
            rst = ($urandom_range(0, 49) == 0);
            for (int i = 0; i < N; i++)
                set_req(i, $urandom_range(0, 9) < 7, $urandom_range(0, 1) == 1,
                        int'($urandom_range(0, 7)), int'($urandom_range(0, 255)));
            sample();
            advance();
        end
        rst = 1'b0;
        clear_reqs();
        sample(); advance();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
